fifo_pair_n: RTL and testbench

//  Parametrised input-pairing buffer for a radix-2 FFT stage.

---
 rtl/fifo_pair_n.sv | 90 +++++++++
 tb/tb_fifo_pair_n.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_pair_n.sv
// Input-pairing buffer for a radix-2 FFT stage: stores the first half of each
// 2*DEPTH block and emits (buffered k, incoming k+DEPTH) pairs during the second half.
module fifo_pair_n #(
    parameter int float_len  = 32,
    parameter int depth_log2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [2*float_len-1:0]  data_in,
    input  logic                    data_in_valid,
    output logic [2*float_len-1:0]  data_out1,
    output logic [2*float_len-1:0]  data_out2,
    output logic                    data_out_valid,
    output logic [depth_log2-1:0]   out_index,
    output logic                    out_last
);

    localparam int SW    = 2 * float_len;
    localparam int DEPTH = 1 << depth_log2;

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [depth_log2-1:0]  cnt, cnt_nxt;
    logic                   cnt_end;
    logic                   accept;
    logic                   wr_en;
    logic                   vld_nxt;
    logic                   last_nxt;
    logic [SW-1:0]          mem [DEPTH];

    assign cnt_end = (cnt == depth_log2'(DEPTH - 1));
    // clr wins over a simultaneous sample, which is simply dropped
    assign accept  = data_in_valid && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
        end else if (data_in_valid) begin
            cnt_nxt = cnt + depth_log2'(1);
            if (cnt_end)
                state_nxt = (state == FILL) ? PAIR : FILL;
        end
    end

    always_comb begin
        wr_en    = accept && (state == FILL);
        vld_nxt  = accept && (state == PAIR);
        last_nxt = vld_nxt && cnt_end;
    end

    // Store has no reset: contents are only ever read after being written this block
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[cnt] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out1      <= '0;
            data_out2      <= '0;
            out_index      <= '0;
            data_out_valid <= 1'b0;
            out_last       <= 1'b0;
        end else begin
            data_out_valid <= vld_nxt;
            out_last       <= last_nxt;
            if (vld_nxt) begin
                data_out1 <= mem[cnt];
                data_out2 <= data_in;
                out_index <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pair_n.sv
// Directed scoreboard bench for fifo_pair_n: DEPTH=16 instance and a DEPTH=2 instance.
module tb_fifo_pair_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_clr, a_vld;
    logic [63:0] a_din, a_o1, a_o2;
    logic        a_ov, a_last;
    logic [3:0]  a_idx;
    logic        b_clr, b_vld;
    logic [31:0] b_din, b_o1, b_o2;
    logic        b_ov, b_last;
    logic [0:0]  b_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] x1;
        logic [63:0] x2;
        int          idx;
        bit          last;
    } pair_t;

    pair_t       sb[$];
    int          m_cnt  [2];
    bit          m_pair [2];
    logic [63:0] h1 [2];
    logic [63:0] h2 [2];
    int          hidx [2];

    always #5 clk = ~clk;

    fifo_pair_n #(.float_len(32), .depth_log2(4)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .data_in(a_din), .data_in_valid(a_vld),
        .data_out1(a_o1), .data_out2(a_o2), .data_out_valid(a_ov),
        .out_index(a_idx), .out_last(a_last)
    );

    fifo_pair_n #(.float_len(16), .depth_log2(1)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .data_in(b_din), .data_in_valid(b_vld),
        .data_out1(b_o1), .data_out2(b_o2), .data_out_valid(b_ov),
        .out_index(b_idx), .out_last(b_last)
    );

    function automatic logic [63:0] samp(input bit sel, input int i);
        if (sel) return {32'd0, 16'(i), 16'(i ^ 32'h5A00)};
        return {32'(i), 32'(i ^ 32'h5A5A_0000)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s]  = 0;
            m_pair[s] = 1'b0;
            h1[s]     = '0;
            h2[s]     = '0;
            hidx[s]   = 0;
        end
        sb.delete();
    endtask

    // One clock: drive at negedge, accept at posedge, check at next negedge
    task automatic step(input bit sel, input bit v, input int i, input bit c);
        int    depth;
        bit    exp_v;
        pair_t e;
        logic [63:0] o1, o2;
        logic        ov, ol;
        int          oi;
        depth = sel ? 2 : 16;
        a_vld = !sel && v;  a_clr = !sel && c;  a_din = samp(1'b0, i);
        b_vld = sel && v;   b_clr = sel && c;   b_din = 32'(samp(1'b1, i));
        @(posedge clk);
        exp_v = 1'b0;
        if (c) begin
            m_cnt[sel]  = 0;
            m_pair[sel] = 1'b0;
        end else if (v) begin
            if (m_pair[sel]) begin
                e.x1   = samp(sel, i - depth);
                e.x2   = samp(sel, i);
                e.idx  = m_cnt[sel];
                e.last = (m_cnt[sel] == depth - 1);
                sb.push_back(e);
                exp_v = 1'b1;
            end
            m_cnt[sel]++;
            if (m_cnt[sel] == depth) begin
                m_cnt[sel]  = 0;
                m_pair[sel] = !m_pair[sel];
            end
        end
        @(negedge clk);
        o1 = sel ? 64'(b_o1) : a_o1;
        o2 = sel ? 64'(b_o2) : a_o2;
        ov = sel ? b_ov : a_ov;
        ol = sel ? b_last : a_last;
        oi = sel ? int'(b_idx) : int'(a_idx);
        if (exp_v) begin
            e = sb.pop_front();
            chk("pair_valid", 64'(ov), 64'(1));
            chk("x1", o1, e.x1);
            chk("x2", o2, e.x2);
            chk("out_index", 64'(oi), 64'(e.idx));
            chk("out_last", 64'(ol), 64'(e.last));
            h1[sel] = e.x1;  h2[sel] = e.x2;  hidx[sel] = e.idx;
        end else begin
            chk("idle_valid", 64'(ov), 64'(0));
            chk("idle_last", 64'(ol), 64'(0));
            chk("hold_x1", o1, h1[sel]);
            chk("hold_x2", o2, h2[sel]);
            chk("hold_index", 64'(oi), 64'(hidx[sel]));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_x1"}, a_o1, 64'd0);
        chk({tag, "_a_x2"}, a_o2, 64'd0);
        chk({tag, "_a_vld"}, 64'(a_ov), 64'd0);
        chk({tag, "_a_idx"}, 64'(a_idx), 64'd0);
        chk({tag, "_a_last"}, 64'(a_last), 64'd0);
        chk({tag, "_b_x1"}, 64'(b_o1), 64'd0);
        chk({tag, "_b_vld"}, 64'(b_ov), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_clr = 0; a_vld = 0; a_din = '0;
        b_clr = 0; b_vld = 0; b_din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Test 1: continuous 0..31
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, i, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);

        // Test 2: two back-to-back blocks
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, i, 1'b0);

        // Test 3: valid toggling with gaps
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, i, 1'b0);
            step(1'b0, 1'b0, 0, 1'b0);
        end

        // Test 4: clr with a concurrent valid sample mid-PAIR
        for (int i = 0; i <= 20; i++) step(1'b0, 1'b1, i, 1'b0);
        step(1'b0, 1'b1, 21, 1'b1);
        for (int i = 100; i < 132; i++) step(1'b0, 1'b1, i, 1'b0);

        // Test 5: async reset between edges mid-FILL
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, 1'b0);
        a_vld = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, i, 1'b0);

        // Test 6: DEPTH=2, 16-bit floats
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
